enter_arbitr_rr_pkt: RTL and testbench

- Parametrised ingress arbiter. Drains NUM_PORTS first-word-fall-through (FWFT) ingress FIFOs into one serial word stream for the shared-buffer write path.
- Work-conserving round-robin: empty ports are skipped, so no slots are wasted.
- Optional packet lock: once a port wins, it keeps the grant until its end-of-packet word.
- Registered output with valid/ready backpressure; sustains 1 word/cycle.

---
 rtl/enter_arbitr_rr_pkt_pkg.sv | 27 ++
 rtl/enter_arbitr_rr_pkt_rr_find_first.sv | 37 +++
 rtl/enter_arbitr_rr_pkt.sv | 186 ++++++++++++++++++
 tb/tb_enter_arbitr_rr_pkt.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enter_arbitr_rr_pkt_pkg.sv
// Shared defines and types for the enter_arbitr_rr_pkt ingress arbiter.
// Provides the default word width, default port count and a clog2 helper macro.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif

`ifndef ENTER_ARB_NUM_PORTS
`define ENTER_ARB_NUM_PORTS 4
`endif

`ifndef ENTER_ARB_CLOG2
`define ENTER_ARB_CLOG2(n) (((n) > 1) ? $clog2(n) : 1)
`endif

package enter_arbitr_rr_pkt_pkg;

    typedef enum logic {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Port-index width; a single-port arbiter still carries a 1-bit index.
    function automatic int ptr_width(input int n);
        return `ENTER_ARB_CLOG2(n);
    endfunction

endpackage

// File: rtl/enter_arbitr_rr_pkt_rr_find_first.sv
// Rotating first-set search: returns the first asserted request at or after ptr,
// wrapping modulo NUM_PORTS.
module rr_find_first
    import enter_arbitr_rr_pkt_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int PW        = ptr_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PW-1:0]        ptr,
    output logic                 found,
    output logic [PW-1:0]        index
);

    logic [NUM_PORTS-1:0] rot;
    int                   slot;

    // rot[i] is the request of port (ptr + i) mod NUM_PORTS
    assign rot = NUM_PORTS'({req, req} >> ptr);

    always_comb begin
        found = 1'b0;
        index = '0;
        slot  = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                slot  = int'(ptr) + i;
                if (slot >= NUM_PORTS) begin
                    slot = slot - NUM_PORTS;
                end
                index = PW'(slot);
            end
        end
    end

endmodule

// File: rtl/enter_arbitr_rr_pkt.sv
// Work-conserving round-robin ingress arbiter with optional packet lock.
// Define ENTER_ARB_WDT_EN to add the lock watchdog (WDT_CYCLES, o_wdt_err).
module enter_arbitr_rr_pkt
    import enter_arbitr_rr_pkt_pkg::*;
#(
    parameter int NUM_PORTS  = `ENTER_ARB_NUM_PORTS,
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int PKT_MODE   = 1
`ifdef ENTER_ARB_WDT_EN
    ,
    parameter int WDT_CYCLES = 256
`endif
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            i_fifo_empty,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] i_fifo_data,
    input  logic [NUM_PORTS-1:0]            i_fifo_last,
    output logic [NUM_PORTS-1:0]            o_fifo_rd_en,
    output logic [DATA_WIDTH-1:0]           o_sdata,
    output logic                            o_data_valid,
    output logic                            o_data_last,
    output logic [ptr_width(NUM_PORTS)-1:0] o_src_port,
    input  logic                            i_ready
`ifdef ENTER_ARB_WDT_EN
    ,
    output logic                            o_wdt_err
`endif
);

    localparam int PW = ptr_width(NUM_PORTS);

    arb_state_e      state_q, state_d;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   lock_port_q;

    logic [NUM_PORTS-1:0] req;
    logic                 found;
    logic [PW-1:0]        grant;

    logic                  locked;
    logic                  can_load;
    logic                  lock_head_rdy;
    logic                  pop_p0;
    logic                  pop_en_p0;
    logic [PW-1:0]         pop_port_p0;
    logic [DATA_WIDTH-1:0] pop_data_p0;

    logic [DATA_WIDTH-1:0] data_p1;
    logic                  last_p1;
    logic [PW-1:0]         src_p1;
    logic                  vld_p1;

`ifdef ENTER_ARB_WDT_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);
    logic [WDT_W-1:0] wdt_cnt_q;
    logic             wdt_fire;
    logic             wdt_err_q;
`endif

    function automatic logic [PW-1:0] step_ptr(input logic [PW-1:0] p);
        return (p == PW'(NUM_PORTS - 1)) ? '0 : p + PW'(1);
    endfunction

    assign req = ~i_fifo_empty;

    rr_find_first #(
        .NUM_PORTS(NUM_PORTS),
        .PW       (PW)
    ) u_find (
        .req  (req),
        .ptr  (ptr_q),
        .found(found),
        .index(grant)
    );

    assign locked        = (state_q == ARB_LOCKED);
    assign can_load      = ~vld_p1 | i_ready;
    assign lock_head_rdy = ~i_fifo_empty[lock_port_q];

    // Stage p0: select the port to pop this cycle
    always_comb begin
        state_d     = state_q;
        pop_p0      = 1'b0;
        pop_port_p0 = grant;
`ifdef ENTER_ARB_WDT_EN
        wdt_fire    = 1'b0;
`endif
        case (state_q)
            ARB_OPEN: begin
                if (can_load && found) begin
                    pop_p0 = 1'b1;
                    if (PKT_MODE != 0 && !i_fifo_last[grant]) begin
                        state_d = ARB_LOCKED;
                    end
                end
            end
            ARB_LOCKED: begin
                pop_port_p0 = lock_port_q;
                if (can_load && lock_head_rdy) begin
                    pop_p0 = 1'b1;
                    if (i_fifo_last[lock_port_q]) begin
                        state_d = ARB_OPEN;
                    end
                end
`ifdef ENTER_ARB_WDT_EN
                else if (!lock_head_rdy && wdt_cnt_q == WDT_W'(WDT_CYCLES - 1)) begin
                    wdt_fire = 1'b1;
                    state_d  = ARB_OPEN;
                end
`endif
            end
            default: state_d = ARB_OPEN;
        endcase
    end

    // Pops are suppressed while reset is held so upstream FIFOs are untouched
    assign pop_en_p0   = pop_p0 & rst_n;
    assign pop_data_p0 = i_fifo_data[pop_port_p0*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        o_fifo_rd_en = '0;
        if (pop_en_p0) begin
            o_fifo_rd_en[pop_port_p0] = 1'b1;
        end
    end

    // Stage p1: output register, pointer and lock bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_OPEN;
            ptr_q       <= '0;
            lock_port_q <= '0;
            vld_p1      <= 1'b0;
            data_p1     <= '0;
            last_p1     <= 1'b0;
            src_p1      <= '0;
        end else begin
            state_q <= state_d;
            if (pop_en_p0) begin
                data_p1 <= pop_data_p0;
                last_p1 <= i_fifo_last[pop_port_p0];
                src_p1  <= pop_port_p0;
                vld_p1  <= 1'b1;
            end else if (i_ready) begin
                vld_p1 <= 1'b0;
            end
            if (pop_en_p0 && !locked) begin
                ptr_q <= step_ptr(grant);
            end
            if (!locked && state_d == ARB_LOCKED) begin
                lock_port_q <= grant;
            end
`ifdef ENTER_ARB_WDT_EN
            if (wdt_fire) begin
                ptr_q <= step_ptr(lock_port_q);
            end
`endif
        end
    end

`ifdef ENTER_ARB_WDT_EN
    // Counts cycles spent locked onto an empty port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdt_cnt_q <= '0;
            wdt_err_q <= 1'b0;
        end else begin
            wdt_err_q <= wdt_fire;
            if (!locked || pop_en_p0 || wdt_fire) begin
                wdt_cnt_q <= '0;
            end else if (!lock_head_rdy) begin
                wdt_cnt_q <= wdt_cnt_q + WDT_W'(1);
            end
        end
    end

    assign o_wdt_err = wdt_err_q;
`endif

    assign o_sdata      = data_p1;
    assign o_data_valid = vld_p1;
    assign o_data_last  = last_p1;
    assign o_src_port   = src_p1;

endmodule

// File: tb/tb_enter_arbitr_rr_pkt.sv
// Scoreboard bench for enter_arbitr_rr_pkt: a 4-port packet-mode instance and a
// 3-port word-mode instance fed from behavioural FWFT FIFOs.
module tb_enter_arbitr_rr_pkt;

    logic clk;
    logic rst_n;

    // instance A: 4 ports, packet mode
    logic [3:0]  fe_a, fl_a, rd_a;
    logic [63:0] fd_a;
    logic [15:0] sd_a;
    logic        vl_a, ls_a, rdy_a;
    logic [1:0]  src_a;
    // instance B: 3 ports, word mode
    logic [2:0]  fe_b, fl_b, rd_b;
    logic [47:0] fd_b;
    logic [15:0] sd_b;
    logic        vl_b, ls_b, rdy_b;
    logic [1:0]  src_b;
`ifdef ENTER_ARB_WDT_EN
    logic        err_a, err_b;
`endif

    logic [16:0] qa [4][$];
    logic [16:0] qb [3][$];
    logic [18:0] exp_a [$];
    logic [18:0] exp_b [$];

    int vectors     = 0;
    int miscompares = 0;

    enter_arbitr_rr_pkt #(
        .NUM_PORTS(4), .DATA_WIDTH(16), .PKT_MODE(1)
`ifdef ENTER_ARB_WDT_EN
        , .WDT_CYCLES(8)
`endif
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .i_fifo_empty(fe_a), .i_fifo_data(fd_a), .i_fifo_last(fl_a),
        .o_fifo_rd_en(rd_a), .o_sdata(sd_a), .o_data_valid(vl_a),
        .o_data_last(ls_a), .o_src_port(src_a), .i_ready(rdy_a)
`ifdef ENTER_ARB_WDT_EN
        , .o_wdt_err(err_a)
`endif
    );

    enter_arbitr_rr_pkt #(
        .NUM_PORTS(3), .DATA_WIDTH(16), .PKT_MODE(0)
`ifdef ENTER_ARB_WDT_EN
        , .WDT_CYCLES(8)
`endif
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .i_fifo_empty(fe_b), .i_fifo_data(fd_b), .i_fifo_last(fl_b),
        .o_fifo_rd_en(rd_b), .o_sdata(sd_b), .o_data_valid(vl_b),
        .o_data_last(ls_b), .o_src_port(src_b), .i_ready(rdy_b)
`ifdef ENTER_ARB_WDT_EN
        , .o_wdt_err(err_b)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pa(input int k, input logic [15:0] d, input logic l);
        qa[k].push_back({l, d});
    endtask

    task automatic pb(input int k, input logic [15:0] d, input logic l);
        qb[k].push_back({l, d});
    endtask

    task automatic ea(input logic [15:0] d, input logic l, input logic [1:0] s);
        exp_a.push_back({d, l, s});
    endtask

    task automatic eb(input logic [15:0] d, input logic l, input logic [1:0] s);
        exp_b.push_back({d, l, s});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_a();
        int n = 0;
        while (exp_a.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("drain_a_left", 64'(exp_a.size()), 64'd0);
        exp_a.delete();
        repeat (2) @(posedge clk);
    endtask

    task automatic drain_b();
        int n = 0;
        while (exp_b.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        check("drain_b_left", 64'(exp_b.size()), 64'd0);
        exp_b.delete();
        repeat (2) @(posedge clk);
    endtask

    // behavioural FWFT FIFOs: pop on the sampled strobe, then present new heads
    initial begin
        logic [3:0] snap_a;
        logic [2:0] snap_b;
        fe_a = '1; fd_a = '0; fl_a = '0;
        fe_b = '1; fd_b = '0; fl_b = '0;
        forever begin
            @(negedge clk);
            snap_a = rd_a;
            snap_b = rd_b;
            @(posedge clk);
            #2;
            for (int k = 0; k < 4; k++) begin
                if (snap_a[k]) begin
                    if (qa[k].size() > 0) void'(qa[k].pop_front());
                    else check("underflow_a", 64'(k), 64'hFF);
                end
                fe_a[k]          = (qa[k].size() == 0);
                fd_a[k*16 +: 16] = (qa[k].size() > 0) ? qa[k][0][15:0] : 16'h0;
                fl_a[k]          = (qa[k].size() > 0) ? qa[k][0][16] : 1'b0;
            end
            for (int k = 0; k < 3; k++) begin
                if (snap_b[k]) begin
                    if (qb[k].size() > 0) void'(qb[k].pop_front());
                    else check("underflow_b", 64'(k), 64'hFF);
                end
                fe_b[k]          = (qb[k].size() == 0);
                fd_b[k*16 +: 16] = (qb[k].size() > 0) ? qb[k][0][15:0] : 16'h0;
                fl_b[k]          = (qb[k].size() > 0) ? qb[k][0][16] : 1'b0;
            end
        end
    end

    // monitors: compare every accepted output word with the scoreboard head
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) check("rd_onehot_a", 64'($onehot0(rd_a)), 64'd1);
            if (vl_a && rdy_a) begin
                if (exp_a.size() == 0) check("unexpected_word_a", {sd_a, ls_a, src_a}, 64'hDEAD);
                else check("word_a", {sd_a, ls_a, src_a}, exp_a.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) check("rd_onehot_b", 64'($onehot0(rd_b)), 64'd1);
            if (vl_b && rdy_b) begin
                if (exp_b.size() == 0) check("unexpected_word_b", {sd_b, ls_b, src_b}, 64'hDEAD);
                else check("word_b", {sd_b, ls_b, src_b}, exp_b.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        rdy_a = 1'b1;
        rdy_b = 1'b1;
        pa(0, 16'hA000, 1'b1);
        pa(1, 16'hB000, 1'b1);
        pa(2, 16'hC000, 1'b1);
        pa(3, 16'hD000, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rd_en", 64'(rd_a), 64'd0);
        check("rst_valid", 64'(vl_a), 64'd0);
        check("rst_sdata", 64'(sd_a), 64'd0);
        check("rst_last",  64'(ls_a), 64'd0);
        check("rst_src",   64'(src_a), 64'd0);
`ifdef ENTER_ARB_WDT_EN
        check("rst_wdt_err", 64'(err_a), 64'd0);
`endif

        // all four ports loaded: one word each, in port order
        ea(16'hA000, 1'b1, 2'd0);
        ea(16'hB000, 1'b1, 2'd1);
        ea(16'hC000, 1'b1, 2'd2);
        ea(16'hD000, 1'b1, 2'd3);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rr_rd_en", 64'(rd_a), 64'(4'b0001 << i));
        end
        drain_a();

        // only ports 1 and 3 active: strict alternation
        step();
        for (int i = 0; i < 3; i++) begin
            pa(1, 16'h1100 + 16'(i), 1'b1);
            pa(3, 16'h3300 + 16'(i), 1'b1);
            ea(16'h1100 + 16'(i), 1'b1, 2'd1);
            ea(16'h3300 + 16'(i), 1'b1, 2'd3);
        end
        drain_a();

        // 3-word packet on port 0 locks out port 2
        step();
        pa(0, 16'h0A00, 1'b0);
        pa(0, 16'h0A01, 1'b0);
        pa(0, 16'h0A02, 1'b1);
        pa(2, 16'h2200, 1'b1);
        ea(16'h0A00, 1'b0, 2'd0);
        ea(16'h0A01, 1'b0, 2'd0);
        ea(16'h0A02, 1'b1, 2'd0);
        ea(16'h2200, 1'b1, 2'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("lock_rd_en", 64'(rd_a), 64'b0001);
        end
        @(negedge clk);
        check("unlock_rd_en", 64'(rd_a), 64'b0100);
        drain_a();

        // backpressure for 5 cycles mid-stream
        step();
        for (int i = 0; i < 5; i++) begin
            pa(1, 16'h4100 + 16'(i), 1'b1);
            ea(16'h4100 + 16'(i), 1'b1, 2'd1);
        end
        step();
        step();
        rdy_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_rd_en", 64'(rd_a), 64'd0);
            check("stall_sdata", 64'(sd_a), 64'h4101);
            check("stall_valid", 64'(vl_a), 64'd1);
        end
        step();
        rdy_a = 1'b1;
        drain_a();

`ifdef ENTER_ARB_WDT_EN
        // port 1 runs dry mid-packet; watchdog releases the lock to port 2
        step();
        pa(1, 16'h5100, 1'b0);
        pa(1, 16'h5101, 1'b0);
        ea(16'h5100, 1'b0, 2'd1);
        ea(16'h5101, 1'b0, 2'd1);
        ea(16'h5200, 1'b1, 2'd2);
        step();
        step();
        pa(2, 16'h5200, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("wdt_quiet_err", 64'(err_a), 64'd0);
            check("wdt_quiet_rd_en", 64'(rd_a), 64'd0);
        end
        @(negedge clk);
        check("wdt_pulse", 64'(err_a), 64'd1);
        check("wdt_next_grant", 64'(rd_a), 64'b0100);
        @(negedge clk);
        check("wdt_pulse_end", 64'(err_a), 64'd0);
        drain_a();
`endif

        // 3-port instance: move ptr to 2, then wrap
        step();
        pb(1, 16'hB100, 1'b1);
        eb(16'hB100, 1'b1, 2'd1);
        drain_b();
        step();
        pb(0, 16'hB001, 1'b1);
        pb(1, 16'hB101, 1'b1);
        pb(2, 16'hB201, 1'b1);
        eb(16'hB201, 1'b1, 2'd2);
        eb(16'hB001, 1'b1, 2'd0);
        eb(16'hB101, 1'b1, 2'd1);
        drain_b();

        // word mode: a multi-word packet does not hold the grant
        step();
        pb(0, 16'hB002, 1'b0);
        pb(0, 16'hB003, 1'b0);
        pb(1, 16'hB102, 1'b1);
        eb(16'hB002, 1'b0, 2'd0);
        eb(16'hB102, 1'b1, 2'd1);
        eb(16'hB003, 1'b0, 2'd0);
        drain_b();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
